// File: rtl/synth_pkg.sv
// Shared constants and encodings for the voice allocation front end.
package synth_pkg;
  localparam int NUM_VOICES  = 256;
  localparam int VOICE_W     = 8;
  localparam int MIDI_W      = 7;
  localparam int HOLD_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    UPD_ALLOC  = 2'd0,
    UPD_RETRIG = 2'd1,
    UPD_STEAL  = 2'd2,
    UPD_OFF    = 2'd3
  } upd_kind_t;
endpackage

// File: rtl/voice_table.sv
// Per-voice active/note storage with one combinational read port, one write port
// and the saturating count of active voices.
module voice_table
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
  parameter int VOICE_W    = synth_pkg::VOICE_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [VOICE_W-1:0]   rd_idx,
  output logic                 rd_active,
  output logic [MIDI_W-1:0]    rd_note,
  input  logic                 wr_en,
  input  logic                 wr_set,
  input  logic [VOICE_W-1:0]   wr_idx,
  input  logic [MIDI_W-1:0]    wr_note,
  input  logic                 cnt_inc,
  input  logic                 cnt_dec,
  output logic [VOICE_W:0]     active_count
);
  localparam logic [VOICE_W:0] CNT_MAX = (VOICE_W+1)'(NUM_VOICES);

  logic [NUM_VOICES-1:0] active;
  logic [MIDI_W-1:0]     note_mem [NUM_VOICES];

  assign rd_active = active[rd_idx];
  assign rd_note   = note_mem[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active       <= '0;
      active_count <= '0;
      for (int i = 0; i < NUM_VOICES; i++) note_mem[i] <= '0;
    end else begin
      if (wr_en) begin
        active[wr_idx] <= wr_set;
        if (wr_set) note_mem[wr_idx] <= wr_note;
      end
      if (cnt_inc && active_count != CNT_MAX)
        active_count <= active_count + 1'b1;
      else if (cnt_dec && active_count != '0)
        active_count <= active_count - 1'b1;
    end
  end
endmodule

// File: rtl/voice_allocator.sv
// Turns MIDI note events into held per-voice updates: retrigger, first free voice,
// or round-robin steal for note-on; matching voice for note-off.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES  = synth_pkg::NUM_VOICES,
  parameter int VOICE_W     = synth_pkg::VOICE_W,
  parameter int HOLD_CYCLES = synth_pkg::HOLD_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 evt_valid,
  output logic                 evt_ready,
  input  logic                 evt_note_on,
  input  logic [MIDI_W-1:0]    evt_note,
  input  logic [MIDI_W-1:0]    evt_velocity,
  output logic                 upd_note_status,
  output logic [VOICE_W-1:0]   upd_voice_index,
  output logic [MIDI_W-1:0]    upd_midi_note,
  output logic [MIDI_W-1:0]    upd_velocity,
  output logic                 upd_ready_flag,
  output logic                 voice_stolen,
  output logic [VOICE_W:0]     active_count
);
  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0]    HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [VOICE_W-1:0] IDX_LAST  = VOICE_W'(NUM_VOICES - 1);

  state_t              state, state_nxt;
  upd_kind_t           sel_kind;
  logic [VOICE_W-1:0]  idx, free_idx, sel_voice, steal_ptr, free_sel;
  logic                free_found, lat_on, hit, scan_last, free_now;
  logic [MIDI_W-1:0]   lat_note, lat_vel, rd_note;
  logic                rd_active;
  logic [HC_W-1:0]     hold_cnt;

  voice_table #(.NUM_VOICES(NUM_VOICES), .VOICE_W(VOICE_W)) u_table (
    .clk          (clk),
    .reset        (reset),
    .rd_idx       (idx),
    .rd_active    (rd_active),
    .rd_note      (rd_note),
    .wr_en        (state == ST_EMIT),
    .wr_set       (sel_kind != UPD_OFF),
    .wr_idx       (sel_voice),
    .wr_note      (lat_note),
    .cnt_inc      (state == ST_EMIT && sel_kind == UPD_ALLOC),
    .cnt_dec      (state == ST_EMIT && sel_kind == UPD_OFF),
    .active_count (active_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    hit       = rd_active && (rd_note == lat_note);
    scan_last = (idx == IDX_LAST);
    free_now  = free_found || !rd_active;
    free_sel  = free_found ? free_idx : idx;
    evt_ready = (state == ST_IDLE);
    state_nxt = state;
    case (state)
      ST_IDLE: if (evt_valid) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (hit)            state_nxt = ST_EMIT;
        else if (scan_last) state_nxt = lat_on ? ST_EMIT : ST_IDLE;
      end
      ST_EMIT: state_nxt = ST_HOLD;
      ST_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx             <= '0;
      free_idx        <= '0;
      free_found      <= 1'b0;
      sel_voice       <= '0;
      sel_kind        <= UPD_ALLOC;
      steal_ptr       <= '0;
      lat_on          <= 1'b0;
      lat_note        <= '0;
      lat_vel         <= '0;
      hold_cnt        <= '0;
      upd_note_status <= 1'b0;
      upd_voice_index <= '0;
      upd_midi_note   <= '0;
      upd_velocity    <= '0;
      upd_ready_flag  <= 1'b0;
      voice_stolen    <= 1'b0;
    end else begin
      upd_ready_flag <= 1'b0;
      voice_stolen   <= 1'b0;
      case (state)
        ST_IDLE: if (evt_valid) begin
          // A zero-velocity note-on is a note-off by MIDI convention
          lat_on     <= evt_note_on && (evt_velocity != '0);
          lat_note   <= evt_note;
          lat_vel    <= evt_velocity;
          idx        <= '0;
          free_found <= 1'b0;
        end
        ST_SCAN: begin
          idx <= idx + 1'b1;
          if (lat_on && !rd_active && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          if (hit) begin
            sel_voice <= idx;
            sel_kind  <= lat_on ? UPD_RETRIG : UPD_OFF;
          end else if (scan_last && lat_on) begin
            if (free_now) begin
              sel_voice <= free_sel;
              sel_kind  <= UPD_ALLOC;
            end else begin
              sel_voice <= steal_ptr;
              sel_kind  <= UPD_STEAL;
              steal_ptr <= steal_ptr + 1'b1;
            end
          end
        end
        ST_EMIT: begin
          upd_note_status <= (sel_kind != UPD_OFF);
          upd_voice_index <= sel_voice;
          upd_midi_note   <= lat_note;
          upd_velocity    <= (sel_kind == UPD_OFF) ? '0 : lat_vel;
          upd_ready_flag  <= 1'b1;
          voice_stolen    <= (sel_kind == UPD_STEAL);
          hold_cnt        <= '0;
        end
        ST_HOLD: hold_cnt <= hold_cnt + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Randomized and directed bench for voice_allocator against an event-level reference model.
module tb_voice_allocator;
  localparam int N  = 16;
  localparam int VW = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          evt_valid = 1'b0;
  logic          evt_ready;
  logic          evt_note_on = 1'b0;
  logic [6:0]    evt_note = '0;
  logic [6:0]    evt_velocity = '0;
  logic          upd_note_status;
  logic [VW-1:0] upd_voice_index;
  logic [6:0]    upd_midi_note;
  logic [6:0]    upd_velocity;
  logic          upd_ready_flag;
  logic          voice_stolen;
  logic [VW:0]   active_count;

  voice_allocator #(.NUM_VOICES(N), .VOICE_W(VW), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_note_on(evt_note_on), .evt_note(evt_note), .evt_velocity(evt_velocity),
    .upd_note_status(upd_note_status), .upd_voice_index(upd_voice_index),
    .upd_midi_note(upd_midi_note), .upd_velocity(upd_velocity),
    .upd_ready_flag(upd_ready_flag), .voice_stolen(voice_stolen),
    .active_count(active_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: voice table, steal pointer, count and the pending update
  bit m_active [N];
  int m_note   [N];
  int m_steal, m_count;
  int p_at, ready_at, p_status, p_voice, p_note, p_vel, p_count;
  bit p_stolen;
  int last_lat, last_voice;
  bit last_stolen;

  // Values the outputs must currently hold
  int h_status, h_voice, h_note, h_vel, exp_count;
  bit ef, es;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin m_active[i] = 1'b0; m_note[i] = 0; end
    m_steal = 0; m_count = 0; p_at = -1; ready_at = 0;
  endfunction

  function automatic void model_accept(input bit on, input int note, input int vel, input int e);
    bit eff_on = on && (vel != 0);
    int hit = -1;
    int fr = -1;
    for (int i = 0; i < N; i++)
      if (hit < 0 && m_active[i] && m_note[i] == note) hit = i;
    p_stolen = 1'b0;
    p_note = note;
    if (hit >= 0) begin
      last_lat = hit + 2;
      p_voice = hit;
      if (eff_on) begin
        p_status = 1; p_vel = vel;
      end else begin
        p_status = 0; p_vel = 0; m_active[hit] = 1'b0; m_count--;
      end
    end else if (eff_on) begin
      last_lat = N + 1;
      for (int i = N - 1; i >= 0; i--) if (!m_active[i]) fr = i;
      if (fr >= 0) begin
        p_voice = fr; m_count++;
      end else begin
        p_voice = m_steal; p_stolen = 1'b1; m_steal = (m_steal + 1) % N;
      end
      m_active[p_voice] = 1'b1; m_note[p_voice] = note;
      p_status = 1; p_vel = vel;
    end else begin
      last_lat = -1; p_at = -1; ready_at = e + N; last_stolen = 1'b0;
      return;
    end
    p_count = m_count;
    p_at = e + last_lat;
    ready_at = p_at + H;
    last_voice = p_voice;
    last_stolen = p_stolen;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      h_status = 0; h_voice = 0; h_note = 0; h_vel = 0; exp_count = 0;
    end else if (chk_en) begin
      ef = 1'b0; es = 1'b0;
      if (cyc == p_at) begin
        h_status = p_status; h_voice = p_voice; h_note = p_note; h_vel = p_vel;
        exp_count = p_count; ef = 1'b1; es = p_stolen;
      end
      chk("upd_ready_flag", int'(upd_ready_flag), int'(ef));
      chk("voice_stolen", int'(voice_stolen), int'(es));
      chk("upd_note_status", int'(upd_note_status), h_status);
      chk("upd_voice_index", int'(upd_voice_index), h_voice);
      chk("upd_midi_note", int'(upd_midi_note), h_note);
      chk("upd_velocity", int'(upd_velocity), h_vel);
      chk("active_count", int'(active_count), exp_count);
      chk("evt_ready", int'(evt_ready), int'(cyc >= ready_at));
    end
  end

  task automatic send(input bit on, input int note, input int vel, output int e);
    int t = 0;
    @(negedge clk);
    evt_valid = 1'b1; evt_note_on = on; evt_note = 7'(note); evt_velocity = 7'(vel);
    while (!evt_ready && t < 200) begin @(negedge clk); t++; end
    if (!evt_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: evt_ready stayed 0 for %0d cycles, required 1", t);
      evt_valid = 1'b0; e = -1;
      return;
    end
    @(posedge clk); #1;
    e = cyc;
    model_accept(on, note, vel, e);
    evt_valid = 1'b0;
  endtask

  task automatic settle();
    int t = 0;
    do begin @(negedge clk); t++; end
    while (!(cyc > p_at && cyc >= ready_at) && t < 100);
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL settle_timeout: no idle after %0d cycles, required < 100", t);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    chk_en = 1'b0; reset = 1'b1;
    #1;
    chk("rst_evt_ready", int'(evt_ready), 1);
    chk("rst_active_count", int'(active_count), 0);
    chk("rst_upd_ready_flag", int'(upd_ready_flag), 0);
    chk("rst_upd_voice_index", int'(upd_voice_index), 0);
    @(negedge clk); #2;
    reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    model_reset();
    repeat (3) @(negedge clk);
    do_reset();

    // Fresh table: first note-on allocates voice 0 after a full scan
    send(1'b1, 60, 100, e);
    chk("lat_first_on", last_lat, N + 1);
    settle();
    chk("v_first_on", int'(upd_voice_index), 0);
    chk("note_first_on", int'(upd_midi_note), 60);
    chk("vel_first_on", int'(upd_velocity), 100);
    chk("cnt_first_on", int'(active_count), 1);

    send(1'b1, 62, 90, e); settle();
    chk("v_62", int'(upd_voice_index), 1);
    send(1'b1, 64, 80, e); settle();
    chk("v_64", int'(upd_voice_index), 2);
    chk("cnt_three", int'(active_count), 3);

    send(1'b0, 62, 0, e);
    chk("lat_off_62", last_lat, 3);
    settle();
    chk("v_off_62", int'(upd_voice_index), 1);
    chk("status_off_62", int'(upd_note_status), 0);
    chk("vel_off_62", int'(upd_velocity), 0);
    chk("cnt_after_off", int'(active_count), 2);

    send(1'b1, 60, 110, e);
    chk("lat_retrig", last_lat, 2);
    settle();
    chk("v_retrig", int'(upd_voice_index), 0);
    chk("cnt_retrig", int'(active_count), 2);

    // Unmatched note-off and zero-velocity note-on are dropped
    send(1'b0, 99, 0, e); settle();
    send(1'b1, 98, 0, e);
    chk("drop_ready_at", ready_at - e, N);
    settle();
    chk("v_after_drop", int'(upd_voice_index), 0);
    chk("vel_after_drop", int'(upd_velocity), 110);

    for (int k = 0; k < N - 2; k++) begin send(1'b1, 70 + k, 50, e); settle(); end
    chk("cnt_full", int'(active_count), N);
    send(1'b1, 90, 40, e);
    chk("steal0_flag", int'(last_stolen), 1);
    settle();
    chk("v_steal0", int'(upd_voice_index), 0);
    send(1'b1, 91, 41, e); settle();
    chk("v_steal1", int'(upd_voice_index), 1);
    chk("cnt_after_steal", int'(active_count), N);

    // Reset in the middle of a scan aborts the event
    send(1'b1, 92, 5, e);
    repeat (3) @(negedge clk);
    do_reset();
    repeat (N + H + 4) @(negedge clk);
    send(1'b1, 60, 100, e); settle();
    chk("v_after_reset", int'(upd_voice_index), 0);
    chk("cnt_after_reset", int'(active_count), 1);

    for (int k = 0; k < 300; k++) begin
      bit on;
      int note, vel;
      on   = ($urandom_range(0, 3) != 0);
      note = 40 + int'($urandom_range(0, 23));
      vel  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
      send(on, note, vel, e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    settle();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
